// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC32 frame checker.
package crc_pkg;

    localparam int CRC_W     = 32;
    localparam int FCS_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_CHECK,
        ST_REPORT
    } state_t;

    // Length travels alongside in the top because its width is a top parameter.
    typedef struct packed {
        logic ok;
        logic runt;
        logic abort;
    } res_flags_t;

endpackage

// File: rtl/crc_fcs_delay.sv
// Four-byte delay line that holds back the trailing FCS; the byte falling off
// the far end is a payload byte once the line has been filled.
module crc_fcs_delay
    import crc_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             shift_en,
    input  logic             flush,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             dout_valid,
    output logic [CRC_W-1:0] fcs
);

    // Element 0 is the newest byte, element FCS_BYTES-1 the oldest.
    logic [FCS_BYTES-1:0][7:0] dl_q;
    logic [2:0]                cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dl_q  <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            dl_q <= {dl_q[FCS_BYTES-2:0], din};
            if (flush)
                cnt_q <= 3'd1;
            else if (cnt_q != 3'(FCS_BYTES))
                cnt_q <= cnt_q + 3'd1;
        end
    end

    assign dout       = dl_q[FCS_BYTES-1];
    assign dout_valid = shift_en && !flush && (cnt_q == 3'(FCS_BYTES));
    assign fcs        = dl_q;

endmodule

// File: rtl/crc_frame_checker.sv
// Frame front end for a byte-wise CRC32 accumulator: strips the FCS, feeds the
// payload to the accumulator and reports ok / runt / abort plus frame length.
module crc_frame_checker
    import crc_pkg::*;
#(
    parameter int               LEN_W   = 16,
    parameter int               MIN_LEN = 5,
    parameter logic [CRC_W-1:0] FCS_XOR = '0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic             crc_clr_n,
    output logic             crc_en,
    output logic [7:0]       crc_data,
    input  logic [CRC_W-1:0] crc_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic             res_runt,
    output logic             res_abort,
    output logic [LEN_W-1:0] res_len
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, len_inc;
    res_flags_t       res_q, res_d;
    logic             dl_shift, dl_flush, dl_valid;
    logic [7:0]       dl_dout;
    logic [CRC_W-1:0] dl_fcs;

    crc_fcs_delay u_delay (
        .clock      (clock),
        .resetn     (resetn),
        .shift_en   (dl_shift),
        .flush      (dl_flush),
        .din        (in_data),
        .dout       (dl_dout),
        .dout_valid (dl_valid),
        .fcs        (dl_fcs)
    );

    assign len_inc = (len_q == '1) ? len_q : len_q + LEN_W'(1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        crc_clr_n = 1'b1;
        dl_shift  = 1'b0;
        dl_flush  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready  = 1'b1;
                crc_clr_n = 1'b0;
                if (in_valid && in_sof) begin
                    dl_shift = 1'b1;
                    dl_flush = 1'b1;
                    len_d    = LEN_W'(1);
                    res_d    = '0;
                    if (in_eof) begin
                        res_d.runt = 1'b1;
                        state_d    = ST_REPORT;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL, ST_RUN: begin
                // A new sof is refused here so it can restart cleanly from IDLE.
                if (in_valid && in_sof) begin
                    res_d.abort = 1'b1;
                    state_d     = ST_REPORT;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        dl_shift = 1'b1;
                        len_d    = len_inc;
                        if (in_eof) begin
                            if (len_inc < LEN_W'(MIN_LEN)) begin
                                res_d.runt = 1'b1;
                                state_d    = ST_REPORT;
                            end else begin
                                state_d = ST_CHECK;
                            end
                        end else if (state_q == ST_FILL && len_inc == LEN_W'(FCS_BYTES)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            ST_CHECK: begin
                res_d.ok = ((crc_in ^ FCS_XOR) == dl_fcs);
                state_d  = ST_REPORT;
            end
            ST_REPORT: begin
                if (res_ready) begin
                    res_d   = '0;
                    len_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign crc_en    = dl_valid;
    assign crc_data  = dl_valid ? dl_dout : '0;
    assign res_valid = (state_q == ST_REPORT);
    assign res_ok    = res_q.ok;
    assign res_runt  = res_q.runt;
    assign res_abort = res_q.abort;
    assign res_len   = len_q;

endmodule
